mac_dot_pipe: RTL and testbench
===============================

Name: mac_dot_pipe

Overview:
Parametrised, pipelined unsigned multiply-add / dot-product engine, successor to the single-stage A*B+C datapath.
Two modes per sample:
- MULADD: data_out = A*B + C.
- DOT: accumulates A*B over DOT_LEN valid samples and emits one result per frame.
Adds valid qualification, asynchronous reset, saturation and frame control. Sits in the signal-processing datapath, fed by sample sources on the 200 MHz clk domain.

Parameters:
W_A, 8, width of operand A
W_B, 8, width of operand B
W_C, 16, width of addend C (must be <= W_ACC)
W_ACC, 24, width of accumulator and data_out (must be >= W_A+W_B)
DOT_LEN, 4, samples per DOT frame (>= 1)

Ports:
clk  in  1  system clock, 200 MHz, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  sample qualifier for a, b, c, mode
mode  in  1  0 = MULADD, 1 = DOT (mac_mode_t)
a  in  W_A  operand A, unsigned
b  in  W_B  operand B, unsigned
c  in  W_C  addend, unsigned; ignored in DOT
clear  in  1  synchronous abort of the current DOT frame
out_valid  out  1  one-cycle pulse: data_out holds a new result
data_out  out  W_ACC  result, unsigned, saturated
sat  out  1  result was clamped; valid with out_valid
dot_done  out  1  one-cycle pulse with out_valid on a DOT result

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release):
  - out_valid, dot_done, sat, data_out = 0.
  - Accumulator, frame counter and all stage valids = 0.
  - A reset mid-frame discards partial sums and in-flight samples.
- Pipeline, 3 register stages:
  - S1 registers a, b, c, mode, in_valid.
  - S2 computes prod = a*b (W_A+W_B bits, unsigned).
  - S3 performs the add/accumulate and drives the outputs.
- Latency:
  - MULADD: out_valid exactly 3 cycles after the accepted sample.
  - DOT: out_valid 3 cycles after the DOT_LEN-th accepted DOT sample.
  - Throughput 1 sample/cycle; no backpressure.
- in_valid=0: bubble.
  - No state change in S3; out_valid=0, dot_done=0.
  - data_out and sat hold their last values.
- MULADD at S3:
  - sum = prod + zero-extended c, computed at W_ACC+1 bits.
  - If sum > 2^W_ACC-1: data_out = all ones, sat=1; else data_out = sum, sat=0.
  - Does not touch the accumulator or counter, so a partial DOT frame survives interleaved MULADD samples.
- DOT at S3:
  - acc_next = acc + prod, saturating at all ones. Set a sticky frame_sat flag on overflow.
  - cnt increments; cnt width is $clog2(DOT_LEN+1).
  - On the sample where cnt reaches DOT_LEN:
    - data_out = acc_next, sat = frame_sat (including this sample); out_valid=1, dot_done=1.
    - acc, cnt and frame_sat return to 0 on the same edge.
  - Otherwise out_valid=0.
  - DOT_LEN=1: every DOT sample produces a result.
- clear (sampled at S3 time, i.e. the same edge as the S3 update):
  - Without a DOT sample in S3: acc, cnt, frame_sat = 0; no output.
  - With a DOT sample in S3: that sample starts a fresh frame (acc=prod, cnt=1, frame_sat=0), or completes it immediately if DOT_LEN=1.
  - With a MULADD sample in S3: the MULADD result is emitted normally and the frame is still cleared.
  - clear does not flush S1/S2.
- Mode is carried per sample through the pipeline; changing mode on any cycle is legal.

Decomposition:
- Shared package mac_pkg:
  - typedef enum logic {MAC_MULADD, MAC_DOT} mac_mode_t
  - default width constants W_A/W_B/W_C/W_ACC/DOT_LEN
  - saturating-add function sat_add(x, y, w)
- Sub-module mac_mult_stage: S1+S2 operand registering and multiply, parametrised W_A/W_B, reset rst_n. Reusable by other datapaths.
- Top module holds S3, the accumulator and the frame counter.

Test Plan:
1. Reset, then MULADD a=10, b=20, c=5 at cycle 0 -> at cycle 3: out_valid=1, data_out=205, sat=0, dot_done=0; out_valid=0 at cycles 1, 2 and 4.
2. Back-to-back DOT (a,b) = (1,2),(3,4),(5,6),(7,8) -> exactly one out_valid/dot_done pulse, 3 cycles after the 4th sample; data_out=100; next frame (2,2)x4 -> 16.
3. W_ACC=16 override, MULADD a=255, b=255, c=65535 -> data_out=0xFFFF, sat=1. Following MULADD a=1, b=1, c=1 -> data_out=2, sat=0.
4. DOT samples (2,3),(2,3), MULADD (4,4,1) interleaved, then (2,3),(2,3) -> MULADD result 17 with dot_done=0, then DOT result 24.
5. DOT (5,5),(5,5), clear coinciding with the 3rd DOT (1,1) in S3, then (1,1),(1,1),(1,1) -> single result 4; the earlier 50 is discarded.
6. rst_n asserted asynchronously (mid-cycle) after 2 DOT samples, released, then 4 DOT (1,1) -> outputs zero during reset; result 4 only.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared mode type, default widths and saturating add for the MAC datapaths
package mac_pkg;
  typedef enum logic {MAC_MULADD, MAC_DOT} mac_mode_t;
  localparam int MAC_W_A = 8;
  localparam int MAC_W_B = 8;
  localparam int MAC_W_C = 16;
  localparam int MAC_W_ACC = 24;
  localparam int MAC_DOT_LEN = 4;
  // packs {sum clamped to w bits, overflow} from bit 0 up, so callers size-cast to w+1 bits
  function automatic logic [64:0] sat_add(input logic [63:0] x, input logic [63:0] y, input int unsigned w);
    logic [64:0] s, m;
    s = {1'b0, x} + {1'b0, y};
    m = (65'd1 << w) - 65'd1;
    return (s > m) ? {m[63:0], 1'b1} : {s[63:0], 1'b0};
  endfunction
endpackage

// File: rtl/mac_mult_stage.sv
// mac_mult_stage: two-stage operand register and unsigned multiply, with a sideband carried alongside
module mac_mult_stage #(
  parameter int W_A = 8,
  parameter int W_B = 8,
  parameter int W_S = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [W_A-1:0]       a,
  input  logic [W_B-1:0]       b,
  input  logic [W_S-1:0]       side,
  output logic                 out_valid,
  output logic [W_A+W_B-1:0]   prod,
  output logic [W_S-1:0]       side_out
);
  logic v1;
  logic [W_A-1:0] a1;
  logic [W_B-1:0] b1;
  logic [W_S-1:0] s1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      s1 <= '0;
      out_valid <= 1'b0;
      prod <= '0;
      side_out <= '0;
    end else begin
      v1 <= in_valid;
      a1 <= a;
      b1 <= b;
      s1 <= side;
      out_valid <= v1;
      prod <= (W_A+W_B)'(a1) * (W_A+W_B)'(b1);
      side_out <= s1;
    end
endmodule

// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: pipelined saturating multiply-add / dot-product engine; S1/S2 in mac_mult_stage, S3 here
module mac_dot_pipe import mac_pkg::*; #(
  parameter int W_A = MAC_W_A,
  parameter int W_B = MAC_W_B,
  parameter int W_C = MAC_W_C,
  parameter int W_ACC = MAC_W_ACC,
  parameter int DOT_LEN = MAC_DOT_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  mac_mode_t        mode,
  input  logic [W_A-1:0]   a,
  input  logic [W_B-1:0]   b,
  input  logic [W_C-1:0]   c,
  input  logic             clear,
  output logic             out_valid,
  output logic [W_ACC-1:0] data_out,
  output logic             sat,
  output logic             dot_done
);
  localparam int W_P = W_A + W_B;
  localparam int W_CNT = $clog2(DOT_LEN + 1);
  logic v2;
  logic [W_P-1:0] prod;
  logic [W_C:0] side2;
  mac_mode_t mode2;
  logic [W_C-1:0] c2;
  logic [W_ACC-1:0] acc;
  logic [W_CNT-1:0] cnt, cnt_nx;
  logic frame_sat, fsat_nx, is_dot, is_mul, done;
  logic [W_ACC:0] mul_r, dot_r;
  mac_mult_stage #(.W_A(W_A), .W_B(W_B), .W_S(W_C + 1)) u_mult (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .side({mode, c}),
    .out_valid(v2),
    .prod(prod),
    .side_out(side2)
  );
  // clear zeroes the frame state seen by this edge, so a DOT sample alongside it starts a new frame
  always_comb begin
    mode2 = mac_mode_t'(side2[W_C]);
    c2 = side2[W_C-1:0];
    is_dot = v2 && mode2 == MAC_DOT;
    is_mul = v2 && mode2 == MAC_MULADD;
    mul_r = (W_ACC+1)'(sat_add(64'(prod), 64'(c2), W_ACC));
    dot_r = (W_ACC+1)'(sat_add(64'(clear ? '0 : acc), 64'(prod), W_ACC));
    fsat_nx = (frame_sat && !clear) || dot_r[0];
    cnt_nx = (clear ? '0 : cnt) + W_CNT'(1);
    done = cnt_nx == W_CNT'(DOT_LEN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      dot_done <= 1'b0;
      sat <= 1'b0;
      data_out <= '0;
      acc <= '0;
      cnt <= '0;
      frame_sat <= 1'b0;
    end else begin
      out_valid <= is_mul || (is_dot && done);
      dot_done <= is_dot && done;
      if (is_mul) begin
        data_out <= mul_r[W_ACC:1];
        sat <= mul_r[0];
      end else if (is_dot && done) begin
        data_out <= dot_r[W_ACC:1];
        sat <= fsat_nx;
      end
      acc <= (is_dot && !done) ? dot_r[W_ACC:1] : (is_dot || clear) ? '0 : acc;
      cnt <= (is_dot && !done) ? cnt_nx : (is_dot || clear) ? '0 : cnt;
      frame_sat <= (is_dot && !done) ? fsat_nx : !(is_dot || clear) && frame_sat;
    end
endmodule

// File: tb/tb_mac_dot_pipe.sv
// tb_mac_dot_pipe: directed vectors against the default 24-bit engine and a 16-bit accumulator variant
module tb_mac_dot_pipe;
  import mac_pkg::*;
  localparam mac_mode_t M = MAC_MULADD;
  localparam mac_mode_t D = MAC_DOT;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic clear = 1'b0;
  mac_mode_t mode = MAC_MULADD;
  logic [7:0] a = '0, b = '0;
  logic [15:0] c = '0;
  logic ov, sat, dd, ov16, sat16, dd16;
  logic [23:0] dout;
  logic [15:0] dout16;
  int checks = 0, failures = 0, stepn = 0, nres = 0, rstep = 0, n16 = 0;
  logic [23:0] rd = '0;
  logic rs = 1'b0, rdd = 1'b0, rs16 = 1'b0;
  logic [15:0] rd16 = '0;

  always #5 clk = ~clk;

  mac_dot_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .c(c),
    .clear(clear), .out_valid(ov), .data_out(dout), .sat(sat), .dot_done(dd)
  );
  mac_dot_pipe #(.W_ACC(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .a(a), .b(b), .c(c),
    .clear(clear), .out_valid(ov16), .data_out(dout16), .sat(sat16), .dot_done(dd16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one input cycle; outputs are sampled 1 ns after the edge and any result pulse is recorded
  task automatic step(input logic v, input mac_mode_t m, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [15:0] cc, input logic clr);
    in_valid = v;
    mode = m;
    a = aa;
    b = bb;
    c = cc;
    clear = clr;
    @(posedge clk);
    #1;
    stepn++;
    if (ov) begin
      nres++;
      rd = dout;
      rs = sat;
      rdd = dd;
      rstep = stepn;
    end
    if (ov16) begin
      n16++;
      rd16 = dout16;
      rs16 = sat16;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, M, 8'd0, 8'd0, 16'd0, 1'b0);
  endtask

  initial begin
    int s0, n0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", ov, 0);
    chk("rst_dout", dout, 0);
    chk("rst_sat", sat, 0);
    chk("rst_dd", dd, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 1: MULADD latency and hold
    step(1'b1, M, 8'd10, 8'd20, 16'd5, 1'b0);
    chk("t1_c1_ov", ov, 0);
    idle(1);
    chk("t1_c2_ov", ov, 0);
    idle(1);
    chk("t1_c3_ov", ov, 1);
    chk("t1_c3_dout", dout, 205);
    chk("t1_c3_sat", sat, 0);
    chk("t1_c3_dd", dd, 0);
    idle(1);
    chk("t1_c4_ov", ov, 0);
    chk("t1_hold", dout, 205);
    // 2: back-to-back DOT frames
    s0 = stepn;
    n0 = nres;
    step(1'b1, D, 8'd1, 8'd2, 16'd0, 1'b0);
    step(1'b1, D, 8'd3, 8'd4, 16'd0, 1'b0);
    step(1'b1, D, 8'd5, 8'd6, 16'd0, 1'b0);
    step(1'b1, D, 8'd7, 8'd8, 16'd0, 1'b0);
    idle(3);
    chk("t2_npulse", nres - n0, 1);
    chk("t2_when", rstep - s0, 6);
    chk("t2_dout", rd, 100);
    chk("t2_dd", rdd, 1);
    chk("t2_dd_pulse", dd, 0);
    n0 = nres;
    repeat (4) step(1'b1, D, 8'd2, 8'd2, 16'd99, 1'b0);
    idle(2);
    chk("t2b_n", nres - n0, 1);
    chk("t2b_dout", rd, 16);
    // 3: saturation on the 16-bit accumulator variant
    step(1'b1, M, 8'd255, 8'd255, 16'hFFFF, 1'b0);
    idle(2);
    chk("t3_dout16", rd16, 16'hFFFF);
    chk("t3_sat16", rs16, 1);
    chk("t3_dout24", rd, 130560);
    chk("t3_sat24", rs, 0);
    step(1'b1, M, 8'd1, 8'd1, 16'd1, 1'b0);
    idle(2);
    chk("t3b_dout16", rd16, 2);
    chk("t3b_sat16", rs16, 0);
    repeat (4) step(1'b1, D, 8'd255, 8'd255, 16'd0, 1'b0);
    idle(2);
    chk("t3c_dot16", dout16, 16'hFFFF);
    chk("t3c_sat16", sat16, 1);
    chk("t3c_dd16", dd16, 1);
    chk("t3c_dot24", dout, 260100);
    chk("t3c_sat24", sat, 0);
    // 4: MULADD interleaved in a DOT frame
    step(1'b1, D, 8'd2, 8'd3, 16'd0, 1'b0);
    step(1'b1, D, 8'd2, 8'd3, 16'd0, 1'b0);
    step(1'b1, M, 8'd4, 8'd4, 16'd1, 1'b0);
    step(1'b1, D, 8'd2, 8'd3, 16'd0, 1'b0);
    step(1'b1, D, 8'd2, 8'd3, 16'd0, 1'b0);
    chk("t4_mul_ov", ov, 1);
    chk("t4_mul_dout", dout, 17);
    chk("t4_mul_dd", dd, 0);
    idle(2);
    chk("t4_dot_ov", ov, 1);
    chk("t4_dot_dout", dout, 24);
    chk("t4_dot_dd", dd, 1);
    // 5: clear alongside a DOT sample in S3
    n0 = nres;
    step(1'b1, D, 8'd5, 8'd5, 16'd0, 1'b0);
    step(1'b1, D, 8'd5, 8'd5, 16'd0, 1'b0);
    step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b1);
    step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    idle(2);
    chk("t5_n", nres - n0, 1);
    chk("t5_dout", rd, 4);
    // 5b: clear with S3 empty
    n0 = nres;
    step(1'b1, D, 8'd3, 8'd3, 16'd0, 1'b0);
    idle(2);
    step(1'b0, M, 8'd0, 8'd0, 16'd0, 1'b1);
    repeat (4) step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    idle(2);
    chk("t5b_n", nres - n0, 1);
    chk("t5b_dout", rd, 4);
    // 5c: clear alongside a MULADD sample in S3
    step(1'b1, D, 8'd3, 8'd3, 16'd0, 1'b0);
    step(1'b1, M, 8'd1, 8'd1, 16'd0, 1'b0);
    idle(1);
    step(1'b0, M, 8'd0, 8'd0, 16'd0, 1'b1);
    chk("t5c_mul_ov", ov, 1);
    chk("t5c_mul_dout", dout, 1);
    n0 = nres;
    repeat (4) step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    idle(2);
    chk("t5c_n", nres - n0, 1);
    chk("t5c_dout", rd, 4);
    // 6: asynchronous reset mid-frame
    step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_dout", dout, 0);
    chk("t6_async_ov", ov, 0);
    idle(2);
    chk("t6_rst_ov", ov, 0);
    chk("t6_rst_dout", dout, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = nres;
    repeat (4) step(1'b1, D, 8'd1, 8'd1, 16'd0, 1'b0);
    idle(3);
    chk("t6_n", nres - n0, 1);
    chk("t6_dout", rd, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
